// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential-multiplier controller: state
// encoding and the default timing/width parameters.
package seq_mult_pkg;

  localparam int MUL_CYCLES_DEFAULT = 8;
  localparam int W_DEFAULT          = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Controller for an external multi-cycle multiplier. It accepts one operand
// pair at a time, clears the multiplier for one cycle, steps it for
// MUL_CYCLES+1 cycles, captures the product and holds it until downstream
// takes it. Either operand being zero skips the multiplier entirely.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int W          = W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             mul_en,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             busy
);

  localparam int CW = (MUL_CYCLES < 1) ? 1 : $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_CYCLES);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          take;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          capture;
  logic          zero_done;

  // State, operand, step-counter and result registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
      out_p <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CW'(1);
      end
      if (capture) begin
        out_p <= mul_c;
      end else if (zero_done) begin
        out_p <= '0;
      end
    end
  end

  // Next-state decode and Moore-style handshake/enable outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mul_en     = 1'b0;
    busy       = 1'b1;
    take       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    zero_done  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          take       = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_clr = 1'b1;
        if ((mul_a == '0) || (mul_b == '0)) begin
          zero_done  = 1'b1;
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        mul_en = 1'b1;
        if (cnt == LAST_STEP) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl paired with a shift-add multiplier stand-in.
// A timeline model predicts every output on every cycle from the accepted
// operands and acceptance time; directed and random operations add
// literal product/latency checks on top.
module tb_seq_mult_ctrl;

  localparam int W  = 8;
  localparam int MC = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            mul_en;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic [2*W-1:0]  mul_c;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_p;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int cyc    = 0;
  bit monOn  = 1'b0;

  // model state
  bit             busyM  = 1'b0;
  bit             zeroM  = 1'b0;
  int             accM   = 0;
  int             dueM   = 0;
  logic [2*W-1:0] prodM  = '0;
  logic [2*W-1:0] expOutM = '0;
  logic [W-1:0]   lastA  = '0;
  logic [W-1:0]   lastB  = '0;

  // multiplier stand-in state
  int mstep = 0;

  seq_mult_ctrl #(.MUL_CYCLES(MC), .W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Shift-add multiplier: cleared while mul_en is low, one partial product
  // per enabled edge, complete after W enabled edges.
  always @(posedge clk) begin
    if (!mul_en) begin
      mul_c <= '0;
      mstep <= 0;
    end else if (mstep < W) begin
      if (mul_b[mstep]) mul_c <= mul_c + ({{W{1'b0}}, mul_a} << mstep);
      mstep <= mstep + 1;
    end
  end

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Per-cycle compare against the timeline model, then advance the model.
  always @(negedge clk) begin
    if (monOn) begin
      if (busyM && cyc == dueM) expOutM = prodM;
      checkOutput("mon_in_ready", in_ready, !busyM);
      checkOutput("mon_busy", busy, busyM);
      checkOutput("mon_out_valid", out_valid, busyM && cyc >= dueM);
      checkOutput("mon_mul_en", mul_en,
                  busyM && !zeroM && cyc >= accM + 2 && cyc <= accM + MC + 2);
      checkOutput("mon_mul_a", mul_a, lastA);
      checkOutput("mon_mul_b", mul_b, lastB);
      checkOutput("mon_out_p", out_p, expOutM);
      if (reset_n && in_valid && in_ready) xfers++;
      if (!reset_n) begin
        busyM = 1'b0;
        lastA = '0;
        lastB = '0;
        expOutM = '0;
      end else if (!busyM && in_valid) begin
        busyM = 1'b1;
        accM  = cyc;
        lastA = in_a;
        lastB = in_b;
        zeroM = (in_a == 0) || (in_b == 0);
        prodM = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
        dueM  = cyc + (zeroM ? 2 : MC + 3);
      end else if (busyM && cyc >= dueM && out_ready) begin
        busyM = 1'b0;
      end
    end
    cyc++;
  end

  // One complete operation: offer operands, wait for acceptance and result,
  // optionally stall downstream, then hand the result off.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int holdLow, input bit junk,
                               input logic [2*W-1:0] expP, input int expLat,
                               input int expEn);
    int lat;
    int en;
    int x0;
    bit got;
    x0 = xfers;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = (holdLow == 0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    checkOutput("accept", got, 1);
    if (!got) begin
      @(posedge clk); #1; in_valid = 1'b0;
      return;
    end
    lat = 0; en = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (junk) begin
        in_a = W'($urandom); in_b = W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (lat == 1) checkOutput("load_en_low", mul_en, 0);
      if (mul_en) en++;
      if (out_valid) got = 1'b1;
    end
    checkOutput("result_seen", got, 1);
    checkOutput("latency", lat, expLat);
    checkOutput("en_cycles", en, expEn);
    checkOutput("product", out_p, expP);
    for (int i = 0; i < holdLow; i++) begin
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_product", out_p, expP);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    if (holdLow > 0) begin
      @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checkOutput("ready_after", in_ready, 1);
    checkOutput("valid_after", out_valid, 0);
    checkOutput("one_transfer", xfers - x0, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           noValid;
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 monOn = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_p", out_p, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    applyStimulus(8'h55, 8'h18, 0, 1'b0, 16'h07F8, 11, 9);
    checkOutput("model_pin_55x18", expOutM, 16'h07F8);
    applyStimulus(8'h99, 8'h41, 5, 1'b0, 16'h26D9, 11, 9);
    applyStimulus(8'h00, 8'hFF, 0, 1'b0, 16'h0000, 2, 0);
    applyStimulus(8'hFF, 8'hFF, 2, 1'b0, 16'hFE01, 11, 9);
    checkOutput("model_pin_FFxFF", expOutM, 16'hFE01);
    applyStimulus(8'h21, 8'h0B, 1, 1'b1, 16'h016B, 11, 9);

    // reset asserted in the 4th RUN cycle
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_run_accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_run_en", mul_en, 1);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_p", out_p, 0);
    checkOutput("rst_mul_en", mul_en, 0);
    checkOutput("rst_mul_a", mul_a, 0);
    checkOutput("rst_mul_b", mul_b, 0);
    checkOutput("rst_busy", busy, 0);
    noValid = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) noValid = 1'b0;
    end
    checkOutput("rst_no_valid", noValid, 1);
    out_ready = 1'b0;
    applyStimulus(8'h03, 8'h05, 0, 1'b0, 16'h000F, 11, 9);

    // reset beats a simultaneous transfer
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'h07; in_b = 8'h09; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_prio_busy", busy, 0);
    checkOutput("rst_prio_mul_a", mul_a, 0);

    // randomized operations
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 5) == 0) ra = '0;
      if ($urandom_range(0, 5) == 0) rb = '0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    {{W{1'b0}}, ra} * {{W{1'b0}}, rb},
                    (ra == 0 || rb == 0) ? 2 : MC + 3,
                    (ra == 0 || rb == 0) ? 0 : MC + 1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 8: number of enabled steps the external multiplier needs to finish.
REQ-002 SHALL have parameter W, default 8: operand width; the product is 2*W bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream operand pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller accepts an operand pair.
REQ-007 SHALL have ports in_a and in_b, inputs, W bits each: the operands.
REQ-008 SHALL have port mul_en, output, 1 bit: enable to the multiplier; low clears it, high steps it.
REQ-009 SHALL have ports mul_a and mul_b, outputs, W bits each: operands driven to the multiplier.
REQ-010 SHALL have port mul_c, input, 2*W bits: product from the multiplier.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port out_p, output, 2*W bits: the registered product.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement an FSM with states IDLE, LOAD, RUN and DONE.
REQ-016 SHALL assert in_ready only in IDLE; a transfer occurs on a rising edge where in_valid and in_ready are both high.
REQ-017 SHALL register in_a and in_b on a transfer and drive them on mul_a and mul_b, held stable until the next transfer.
REQ-018 SHALL go IDLE->LOAD on a transfer; in LOAD, mul_en is 0 for exactly one cycle to clear the multiplier.
REQ-019 SHALL go LOAD->DONE with out_p=0 when either operand is 0 (zero shortcut, RUN skipped); otherwise LOAD->RUN.
REQ-020 SHALL hold mul_en=1 in RUN for exactly MUL_CYCLES+1 cycles, counted by a step counter cleared in LOAD.
REQ-021 SHALL sample mul_c into out_p on the edge that ends the last RUN cycle, then go RUN->DONE. Multiplier contract: mul_c is stable after MUL_CYCLES enabled edges while mul_en stays high.
REQ-022 SHALL drive mul_en=0 in IDLE and DONE.
REQ-023 SHALL hold out_valid=1 in DONE and hold out_p stable until out_valid and out_ready are both high on an edge; it then returns to IDLE.
REQ-024 SHALL assert out_valid exactly MUL_CYCLES+3 cycles after the accepting edge when there is no zero shortcut (11 at default), or 2 cycles after it with the shortcut; this latency is independent of out_ready.
REQ-025 SHALL NOT generate back-to-back throughput: in_ready is first high the cycle after the out_valid/out_ready transfer.
REQ-026 SHALL ignore in_valid, in_a and in_b outside IDLE.
REQ-027 SHALL keep out_valid and out_p unchanged when out_ready is held low indefinitely in DONE.

Reset
REQ-028 SHALL, on a clk edge with reset_n=0, enter IDLE and set in_ready=1, out_valid=0, out_p=0, mul_en=0, mul_a=0, mul_b=0, busy=0 and the counter to 0.
REQ-029 SHALL apply reset in any state, including mid-RUN: the product in progress is discarded and no out_valid is produced.
REQ-030 SHALL give reset priority over a simultaneous transfer, which is dropped.

Structure
REQ-031 SHALL define the state encoding typedef and the MUL_CYCLES and W defaults in the shared package seq_mult_pkg.
REQ-032 SHALL be a single module with no sub-module; the bench instantiates seq_mult_ctrl together with the existing sequential multiplier.

Verification
REQ-033 SHALL cover: a=0x55, b=0x18, out_ready=1 -> out_p=0x07F8 with out_valid 11 cycles after acceptance, and mul_en low 1 cycle then high 9 cycles.
REQ-034 SHALL cover: a=0x99, b=0x41, out_ready low 5 cycles after out_valid -> out_p=0x26D9 held stable and in_ready=0 throughout.
REQ-035 SHALL cover: a=0x00, b=0xFF -> out_p=0x0000, out_valid 2 cycles after acceptance, and mul_en never high.
REQ-036 SHALL cover: a=0xFF, b=0xFF -> out_p=0xFE01.
REQ-037 SHALL cover: reset_n low in the 4th RUN cycle -> all outputs at reset values next cycle, no out_valid; the following a=0x03, b=0x05 -> 0x000F.
REQ-038 SHALL cover: in_valid held high with changing operands during RUN -> result reflects only the accepted pair, and exactly one transfer occurs per operation.
